// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants for the UART-side blocks: sync byte, parser state encoding
// and rejection cause codes.
package uart_cmd_parser_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/uart_timeout.sv
// Inter-byte timeout counter: counts idle cycles, saturates at the terminal
// count and flags it on expired.
module uart_timeout #(
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt;

  // Holds at the terminal count instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (cnt != TERM)
      cnt <= cnt + CW'(1);
  end

  assign expired = (cnt == TERM);

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame parser for SYNC, CMD, LEN, payload, CSUM command frames arriving from
// a UART receiver; publishes good frames and reports rejections.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int MAX_PAYLOAD  = 4,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  cmd,
  output logic [31:0] payload,
  output logic [2:0]  payload_len,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [2:0]  fsm_state
);

  // rx_valid is a one-cycle strobe with no back-pressure: rx_data is consumed
  // on every cycle it is high, and the parser only moves on such cycles
  // (the timeout is the only exception).
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  state_t      state, next_state;
  logic [7:0]  cmd_sh, csum;
  logic [31:0] pay_sh;
  logic [2:0]  len_sh;
  logic [1:0]  idx;
  logic        accept, reject;
  logic [1:0]  rej_code;
  logic        expired;

  uart_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_valid || (state == ST_IDLE)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    rej_code   = ERR_NONE;
    case (state)
      ST_IDLE:    if (rx_valid && rx_data == SYNC_BYTE) next_state = ST_CMD;
      ST_CMD:     if (rx_valid) next_state = ST_LEN;
      ST_LEN: begin
        if (rx_valid) begin
          if (rx_data > MAX_LEN) begin
            reject     = 1'b1;
            rej_code   = ERR_LEN;
            next_state = ST_IDLE;
          end else if (rx_data == 8'd0) begin
            next_state = ST_CSUM;
          end else begin
            next_state = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: if (rx_valid && ({1'b0, idx} == len_sh - 3'd1)) next_state = ST_CSUM;
      ST_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum) begin
            accept = 1'b1;
          end else begin
            reject   = 1'b1;
            rej_code = ERR_CSUM;
          end
          next_state = ST_IDLE;
        end
      end
      default:    next_state = ST_IDLE;
    endcase
    // A byte arriving on the terminal-count cycle takes priority.
    if (state != ST_IDLE && !rx_valid && expired) begin
      reject     = 1'b1;
      rej_code   = ERR_TIMEOUT;
      next_state = ST_IDLE;
    end
  end

  // Shadow registers collect the frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_sh <= '0;
      csum   <= '0;
      pay_sh <= '0;
      len_sh <= '0;
      idx    <= '0;
    end else if (rx_valid) begin
      case (state)
        ST_CMD: begin
          cmd_sh <= rx_data;
          csum   <= rx_data;
        end
        ST_LEN: begin
          len_sh <= rx_data[2:0];
          csum   <= csum ^ rx_data;
          pay_sh <= '0;
          idx    <= '0;
        end
        ST_PAYLOAD: begin
          pay_sh[{idx, 3'b000} +: 8] <= rx_data;
          csum <= csum ^ rx_data;
          idx  <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
      cmd         <= '0;
      payload     <= '0;
      payload_len <= '0;
    end else begin
      frame_valid <= accept;
      frame_err   <= reject;
      if (reject) err_code <= rej_code;
      if (accept) begin
        cmd         <= cmd_sh;
        payload     <= pay_sh;
        payload_len <= len_sh;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frame table, timeout and reset
// sequences, then random traffic against a queue-based frame model.
module tb_uart_cmd_parser;

  localparam int MAX = 4;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cmd;
  logic [31:0] payload;
  logic [2:0]  payload_len;
  logic        frame_valid, frame_err, busy;
  logic [1:0]  err_code;
  logic [2:0]  fsm_state;

  uart_cmd_parser #(.MAX_PAYLOAD(MAX), .TIMEOUT_CLKS(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .cmd         (cmd),
    .payload     (payload),
    .payload_len (payload_len),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int fv_seen, fe_seen;
  logic [47:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes of the frame being collected; empty means hunting for sync.
  logic [7:0]  fq[$];
  int          idle;
  logic        m_fv, m_fe;
  logic [1:0]  m_code;
  logic [7:0]  m_cmd;
  logic [31:0] m_pay;
  logic [2:0]  m_len;

  task automatic model_reset();
    fq.delete();
    idle = 0; m_fv = 0; m_fe = 0; m_code = 0; m_cmd = 0; m_pay = 0; m_len = 0;
  endtask

  task automatic model_cycle(input logic v, input logic [7:0] d);
    logic [7:0] x;
    int n;
    m_fv = 0;
    m_fe = 0;
    if (!v) begin
      if (fq.size() != 0) begin
        if (idle == TO - 1) begin
          m_fe = 1; m_code = 2'd3; fq.delete(); idle = 0;
        end else begin
          idle++;
        end
      end
    end else begin
      idle = 0;
      if (fq.size() == 0) begin
        if (d == 8'hAA) fq.push_back(d);
      end else begin
        fq.push_back(d);
        n = fq.size();
        if (n == 3 && int'(d) > MAX) begin
          m_fe = 1; m_code = 2'd2; fq.delete();
        end else if (n >= 4 && n == int'(fq[2]) + 4) begin
          x = 8'h00;
          for (int i = 1; i < n - 1; i++) x = x ^ fq[i];
          if (x == d) begin
            m_fv = 1; m_cmd = fq[1]; m_len = fq[2][2:0]; m_pay = '0;
            for (int i = 0; i < int'(fq[2]); i++) m_pay[8*i +: 8] = fq[3+i];
          end else begin
            m_fe = 1; m_code = 2'd1;
          end
          fq.delete();
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [7:0] d);
    logic [47:0] got, e;
    rx_valid = v;
    rx_data  = v ? d : 8'($urandom);
    @(posedge clk);
    #1;
    model_cycle(v, d);
    exp_q.push_back({m_fv, m_fe, m_code, m_cmd, m_pay, m_len, (fq.size() != 0)});
    got = {frame_valid, frame_err, err_code, cmd, payload, payload_len, busy};
    e = exp_q.pop_front();
    chk("cycle", 64'(got), 64'(e));
    if (frame_valid) fv_seen++;
    if (frame_err)   fe_seen++;
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    repeat (gap) step(1'b0, 8'h00);
    step(1'b1, d);
  endtask

  function automatic int rand_gap();
    if ($urandom_range(0, 19) == 0) return int'($urandom_range(95, 105));
    return int'($urandom_range(0, 2));
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [63:0] bytes;
    int          n;
    int          fv;
    int          fe;
    logic [7:0]  cmd;
    logic [31:0] pay;
    logic [2:0]  len;
    logic [1:0]  code;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] fb[$];
    logic [7:0] c, cs;
    int len, kind;

    tbl[0] = '{64'h0000_3412_3402_10AA, 6, 1, 0, 8'h10, 32'h0000_1234, 3'd2, 2'd0};
    tbl[1] = '{64'h0000_3512_3402_10AA, 6, 0, 1, 8'h10, 32'h0000_1234, 3'd2, 2'd1};
    tbl[2] = '{64'h0000_0000_0005_10AA, 3, 0, 1, 8'h10, 32'h0000_1234, 3'd2, 2'd2};
    tbl[3] = '{64'h0000_0000_2000_20AA, 4, 1, 0, 8'h20, 32'h0000_0000, 3'd0, 2'd2};
    tbl[4] = '{64'h009B_AA01_30AA_FF55, 7, 1, 0, 8'h30, 32'h0000_00AA, 3'd1, 2'd2};
    tbl[5] = '{64'h0144_3322_1104_41AA, 8, 1, 0, 8'h41, 32'h4433_2211, 3'd4, 2'd2};
    tbl[6] = '{64'h0000_0000_00FF_50AA, 3, 0, 1, 8'h41, 32'h4433_2211, 3'd4, 2'd2};
    tbl[7] = '{64'h0000_0000_0011_5500, 3, 0, 0, 8'h41, 32'h4433_2211, 3'd4, 2'd2};

    // reset
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'({frame_valid, frame_err, err_code, cmd, payload, payload_len, busy}), 64'(0));
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) begin
      fv_seen = 0; fe_seen = 0;
      for (int j = 0; j < tbl[t].n; j++) send_byte(tbl[t].bytes[8*j +: 8], 0);
      chk($sformatf("tbl%0d_fv", t),   64'(fv_seen),     64'(tbl[t].fv));
      chk($sformatf("tbl%0d_fe", t),   64'(fe_seen),     64'(tbl[t].fe));
      chk($sformatf("tbl%0d_cmd", t),  64'(cmd),         64'(tbl[t].cmd));
      chk($sformatf("tbl%0d_pay", t),  64'(payload),     64'(tbl[t].pay));
      chk($sformatf("tbl%0d_len", t),  64'(payload_len), 64'(tbl[t].len));
      chk($sformatf("tbl%0d_code", t), 64'(err_code),    64'(tbl[t].code));
      chk($sformatf("tbl%0d_busy", t), 64'(busy),        64'(0));
    end

    // timeout after 100 idle cycles
    fe_seen = 0;
    send_byte(8'hAA, 0); send_byte(8'h10, 0);
    repeat (TO - 1) step(1'b0, 8'h00);
    chk("to_none_before", 64'(fe_seen), 64'(0));
    step(1'b0, 8'h00);
    chk("to_pulse", 64'(frame_err), 64'(1));
    chk("to_code",  64'(err_code),  64'(3));
    chk("to_busy",  64'(busy),      64'(0));

    // byte on idle cycle 99: no timeout
    fv_seen = 0; fe_seen = 0;
    send_byte(8'hAA, 0); send_byte(8'h10, 0);
    send_byte(8'h00, TO - 2);
    send_byte(8'h10, 0);
    chk("to99_fe",  64'(fe_seen), 64'(0));
    chk("to99_fv",  64'(fv_seen), 64'(1));
    chk("to99_cmd", 64'(cmd),     64'(8'h10));
    chk("to99_pay", 64'(payload), 64'(0));

    // byte coinciding with terminal count wins
    fv_seen = 0; fe_seen = 0;
    send_byte(8'hAA, 0); send_byte(8'h30, 0);
    send_byte(8'h01, TO - 1);
    send_byte(8'h55, 0); send_byte(8'h64, 0);
    chk("tc_fe",   64'(fe_seen),  64'(0));
    chk("tc_fv",   64'(fv_seen),  64'(1));
    chk("tc_pay",  64'(payload),  64'(32'h55));
    chk("tc_code", 64'(err_code), 64'(3));

    // reset mid-frame
    fv_seen = 0; fe_seen = 0;
    send_byte(8'hAA, 0); send_byte(8'h10, 0); send_byte(8'h02, 0); send_byte(8'h34, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_outputs", 64'({frame_valid, frame_err, err_code, cmd, payload, payload_len, busy}), 64'(0));
    end
    rst_n = 1'b1;
    send_byte(8'hAA, 0); send_byte(8'h20, 0); send_byte(8'h00, 0); send_byte(8'h20, 0);
    chk("rst_fv",  64'(fv_seen), 64'(1));
    chk("rst_fe",  64'(fe_seen), 64'(0));
    chk("rst_cmd", 64'(cmd),     64'(8'h20));

    // random traffic, every cycle checked against the model
    for (int it = 0; it < 250; it++) begin
      fb.delete();
      kind = int'($urandom_range(0, 9));
      c = 8'($urandom);
      if (kind <= 5) begin
        len = int'($urandom_range(0, MAX));
        fb.push_back(8'hAA); fb.push_back(c); fb.push_back(8'(len));
        cs = c ^ 8'(len);
        for (int k = 0; k < len; k++) begin
          fb.push_back(8'($urandom));
          cs = cs ^ fb[fb.size()-1];
        end
        if (kind == 5) cs = cs ^ 8'($urandom_range(1, 255));
        fb.push_back(cs);
      end else if (kind == 6) begin
        fb.push_back(8'hAA); fb.push_back(c); fb.push_back(8'($urandom_range(MAX + 1, 255)));
      end else if (kind == 7) begin
        repeat ($urandom_range(1, 3)) fb.push_back(8'($urandom));
      end else begin
        fb.push_back(8'hAA); fb.push_back(c); fb.push_back(8'($urandom_range(1, MAX)));
      end
      foreach (fb[k]) send_byte(fb[k], rand_gap());
      if (kind >= 8) repeat (TO + int'($urandom_range(0, 2))) step(1'b0, 8'h00);
    end
    repeat (TO + 2) step(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
